// File: rtl/cpumc_arb_pkg.sv
// Shared constants and state encoding for the cpumc port arbiter / sprite DMA sequencer.
package cpumc_arb_pkg;

    localparam logic [15:0] DMA_TRIG_ADDR = 16'h4014;
    localparam logic [15:0] OAMDATA_ADDR  = 16'h2004;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_CAP  = 2'd2;
    localparam logic [1:0] S_WR   = 2'd3;

    typedef enum logic [1:0] {
        IDLE = S_IDLE,
        RD   = S_RD,
        CAP  = S_CAP,
        WR   = S_WR
    } dma_state_t;

endpackage

// File: rtl/cpumc_arb.sv
// Arbitrates the cpumc port between debugger, sprite OAM DMA and CPU, and runs the
// $4014 page copy: read {page,idx}, hold a cycle for read latency, write byte to OAMDATA.
module cpumc_arb #(
    parameter logic [15:0] DMA_TRIG_ADDR = cpumc_arb_pkg::DMA_TRIG_ADDR,
    parameter logic [15:0] OAMDATA_ADDR  = cpumc_arb_pkg::OAMDATA_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dbg_ready,
    input  logic [15:0] dbg_a,
    input  logic [7:0]  dbg_dout,
    input  logic        dbg_r_nw,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_r_nw,
    input  logic [7:0]  cpumc_dout,
    output logic [15:0] cpumc_a,
    output logic [7:0]  cpumc_din,
    output logic        cpumc_r_nw,
    output logic        cpu_ready,
    output logic        dma_busy
);
    import cpumc_arb_pkg::*;

    dma_state_t state, state_d;
    logic [7:0] idx, idx_d;
    logic [7:0] page, page_d;
    logic [7:0] data, data_d;
    logic       trig;

    assign trig      = (state == IDLE) && dbg_ready && !cpu_r_nw && (cpu_a == DMA_TRIG_ADDR);
    assign dma_busy  = (state != IDLE);
    assign cpu_ready = dbg_ready & ~dma_busy;

    // Whole sequencer freezes while the debugger owns the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= 8'h00;
            page  <= 8'h00;
            data  <= 8'h00;
        end else if (dbg_ready) begin
            state <= state_d;
            idx   <= idx_d;
            page  <= page_d;
            data  <= data_d;
        end
    end

    always_comb begin
        state_d = state;
        idx_d   = idx;
        page_d  = page;
        data_d  = data;
        case (state)
            IDLE: if (trig) begin
                state_d = RD;
                idx_d   = 8'h00;
                page_d  = cpu_dout;
            end
            RD:  state_d = CAP;
            CAP: begin
                data_d  = cpumc_dout;
                state_d = WR;
            end
            WR: if (idx == 8'hFF) begin
                state_d = IDLE;
            end else begin
                idx_d   = idx + 8'd1;
                state_d = RD;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cpumc_a    = cpu_a;
        cpumc_din  = cpu_dout;
        cpumc_r_nw = cpu_r_nw | trig;   // the trigger write itself never reaches memory
        if (!dbg_ready) begin
            cpumc_a    = dbg_a;
            cpumc_din  = dbg_dout;
            cpumc_r_nw = dbg_r_nw;
        end else if (dma_busy) begin
            cpumc_a    = (state == WR) ? OAMDATA_ADDR : {page, idx};
            cpumc_din  = data;
            cpumc_r_nw = (state != WR);
        end
    end

endmodule

// File: tb/tb_cpumc_arb.sv
// Directed bench for cpumc_arb: mux ownership, full page DMA, page FF, debugger preemption,
// mid-DMA reset and near-miss trigger addresses.
module tb_cpumc_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        dbg_ready;
    logic [15:0] dbg_a;
    logic [7:0]  dbg_dout;
    logic        dbg_r_nw;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic        cpu_r_nw;
    logic [7:0]  cpumc_dout;
    logic [15:0] cpumc_a;
    logic [7:0]  cpumc_din;
    logic        cpumc_r_nw;
    logic        cpu_ready;
    logic        dma_busy;

    cpumc_arb dut (
        .clk(clk), .rst(rst),
        .dbg_ready(dbg_ready), .dbg_a(dbg_a), .dbg_dout(dbg_dout), .dbg_r_nw(dbg_r_nw),
        .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_r_nw(cpu_r_nw),
        .cpumc_dout(cpumc_dout), .cpumc_a(cpumc_a), .cpumc_din(cpumc_din),
        .cpumc_r_nw(cpumc_r_nw), .cpu_ready(cpu_ready), .dma_busy(dma_busy)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [65536];
    assign cpumc_dout = mem[cpumc_a];

    int         cyc = 0;
    int         ready_low = 0;
    int         bad_addr = 0;
    int         trig_fwd = 0;
    logic [7:0] exp_page = 8'h00;
    logic [7:0] wr_data[$];
    int         wr_cyc[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!cpu_ready) ready_low <= ready_low + 1;
        if (!cpumc_r_nw && cpumc_a == 16'h2004) begin
            wr_data.push_back(cpumc_din);
            wr_cyc.push_back(cyc);
        end
        if (!cpumc_r_nw && cpumc_a == 16'h4014) trig_fwd <= trig_fwd + 1;
        if (dbg_ready && dma_busy && cpumc_r_nw && cpumc_a[15:8] != exp_page)
            bad_addr <= bad_addr + 1;
    end

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Issue the $4014 write in the current cycle T, leave the bench at negedge of T+1.
    task automatic trigger(input logic [7:0] pg, output int t);
        cpu_a    = 16'h4014;
        cpu_dout = pg;
        cpu_r_nw = 1'b0;
        exp_page = pg;
        t = cyc;
        #1;
        chk("trig_rnw_forced", cpumc_r_nw, 1'b1);
        @(posedge clk);
        #1;
        cpu_a    = 16'h0123;
        cpu_r_nw = 1'b1;
        @(negedge clk);
        chk("busy_at_t1", dma_busy, 1'b1);
        chk("ready_at_t1", cpu_ready, 1'b0);
    endtask

    task automatic wait_done(input string tag, output int n);
        n = 1;
        while (dma_busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_timeout"}, (n < 2000), 1'b1);
    endtask

    task automatic chk_seq(input string tag, input int base, input logic [7:0] key, input logic add);
        chk({tag, "_count"}, wr_data.size() - base, 256);
        for (int i = 0; i < 256; i++) begin
            if (base + i < wr_data.size())
                chk({tag, "_byte"}, wr_data[base + i], add ? 8'(i + 1) : (8'(i) ^ key));
        end
    endtask

    initial begin
        int t, n, base, rl0, ba0;
        logic [15:0] a;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int i = 0; i < 256; i++) begin
            a = 16'h0300 + 16'(i);
            mem[a] = 8'(i) ^ 8'h5A;
            a = 16'hFF00 + 16'(i);
            mem[a] = 8'(i + 1);
        end
        mem[0] = 8'hEE;

        rst = 1'b1; dbg_ready = 1'b1; dbg_a = 16'h0000; dbg_dout = 8'h00; dbg_r_nw = 1'b1;
        cpu_a = 16'h0123; cpu_dout = 8'h00; cpu_r_nw = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_a", cpumc_a, 16'h0123);
        chk("rst_rnw", cpumc_r_nw, 1'b1);
        chk("rst_ready", cpu_ready, 1'b1);
        chk("rst_busy", dma_busy, 1'b0);

        // full page 03
        base = wr_data.size(); rl0 = ready_low;
        trigger(8'h03, t);
        wait_done("p03", n);
        chk("p03_done_cyc", n, 769);
        chk("p03_ready_low", ready_low - rl0, 768);
        chk("p03_last_wr_cyc", wr_cyc[wr_cyc.size() - 1], t + 768);
        chk("p03_first_wr_cyc", wr_cyc[base], t + 3);
        chk_seq("p03", base, 8'h5A, 1'b0);
        chk("p03_ready_after", cpu_ready, 1'b1);

        // page FF: must not wrap into page 00
        base = wr_data.size(); ba0 = bad_addr;
        trigger(8'hFF, t);
        wait_done("pff", n);
        chk("pff_last_wr_cyc", wr_cyc[wr_cyc.size() - 1], t + 768);
        chk("pff_bad_addr", bad_addr - ba0, 0);
        chk_seq("pff", base, 8'h00, 1'b1);

        // debugger preempts 10 cycles starting at CAP idx 40
        base = wr_data.size(); rl0 = ready_low;
        trigger(8'h03, t);
        repeat (193) @(negedge clk);
        chk("pre_cap_a", cpumc_a, 16'h0340);
        dbg_ready = 1'b0; dbg_a = 16'h1234; dbg_r_nw = 1'b1;
        #1;
        chk("dbg_own_a", cpumc_a, 16'h1234);
        chk("dbg_own_ready", cpu_ready, 1'b0);
        repeat (9) @(negedge clk);
        chk("dbg_own_a_last", cpumc_a, 16'h1234);
        chk("dbg_own_busy", dma_busy, 1'b1);
        @(negedge clk);
        dbg_ready = 1'b1;
        #1;
        chk("resume_cap_a", cpumc_a, 16'h0340);
        chk("resume_cap_rnw", cpumc_r_nw, 1'b1);
        @(negedge clk);
        chk("resume_wr_a", cpumc_a, 16'h2004);
        chk("resume_wr_din", cpumc_din, 8'h40 ^ 8'h5A);
        wait_done("pre", n);
        chk("pre_last_wr_cyc", wr_cyc[wr_cyc.size() - 1], t + 778);
        chk("pre_ready_low", ready_low - rl0, 778);
        chk_seq("pre", base, 8'h5A, 1'b0);

        // reset during RD idx 80
        base = wr_data.size();
        trigger(8'h03, t);
        repeat (384) @(negedge clk);
        chk("rst_mid_a", cpumc_a, 16'h0380);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", dma_busy, 1'b0);
        chk("rst_mid_ready", cpu_ready, 1'b1);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("rst_mid_writes", wr_data.size() - base, 128);
        chk("rst_mid_idle", dma_busy, 1'b0);

        // neighbouring addresses are plain writes
        cpu_a = 16'h4013; cpu_dout = 8'hAA; cpu_r_nw = 1'b0;
        #1;
        chk("w4013_a", cpumc_a, 16'h4013);
        chk("w4013_rnw", cpumc_r_nw, 1'b0);
        chk("w4013_din", cpumc_din, 8'hAA);
        @(negedge clk);
        cpu_a = 16'h4015; cpu_dout = 8'h55;
        #1;
        chk("w4013_nodma", dma_busy, 1'b0);
        chk("w4015_a", cpumc_a, 16'h4015);
        chk("w4015_rnw", cpumc_r_nw, 1'b0);
        @(negedge clk);
        chk("w4015_nodma", dma_busy, 1'b0);

        // debugger break coincident with a trigger: debugger wins, no DMA
        cpu_a = 16'h4014; cpu_dout = 8'h03; cpu_r_nw = 1'b0;
        dbg_ready = 1'b0; dbg_a = 16'h0555; dbg_r_nw = 1'b1;
        #1;
        chk("dbg_trig_a", cpumc_a, 16'h0555);
        chk("dbg_trig_rnw", cpumc_r_nw, 1'b1);
        @(negedge clk);
        dbg_ready = 1'b1; cpu_a = 16'h0123; cpu_r_nw = 1'b1;
        chk("dbg_trig_nodma", dma_busy, 1'b0);
        @(negedge clk);
        chk("dbg_trig_nodma2", dma_busy, 1'b0);
        chk("trig_not_forwarded", trig_fwd, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/cpumc_arb.md
# cpumc_arb

Bus arbiter and sequencer for the CPU memory controller (cpumc) port. It shares the single cpumc address/data/R-!W port between three requesters: the debugger (highest priority), an internal sprite OAM DMA engine, and the CPU. It also stalls the CPU through its ready input while it does not own the bus. The block replaces the two-way ready-based mux in the top level, and its DMA engine implements the $4014 sprite-page copy into $2004.

## Interface
Parameters:
- DMA_TRIG_ADDR, 16'h4014, CPU write address that starts a sprite DMA
- OAMDATA_ADDR, 16'h2004, destination address written for every DMA byte

Ports:
- clk  in  1  system clock (50 MHz); single clock domain
- rst  in  1  synchronous, active-high reset
- dbg_ready  in  1  debugger's CPU-ready output; 0 = debugger owns the bus
- dbg_a  in  16  debugger address
- dbg_dout  in  8  debugger write data
- dbg_r_nw  in  1  debugger R/!W
- cpu_a  in  16  CPU address
- cpu_dout  in  8  CPU write data
- cpu_r_nw  in  1  CPU R/!W
- cpumc_dout  in  8  cpumc read data, valid one cycle after the address is presented
- cpumc_a  out  16  muxed address
- cpumc_din  out  8  muxed write data
- cpumc_r_nw  out  1  muxed R/!W
- cpu_ready  out  1  to CPU ready input; equals dbg_ready & ~dma_busy
- dma_busy  out  1  DMA in progress (state != IDLE)

## Operation
- Owner select, combinational, priority order:
  - dbg_ready=0: debugger signals.
  - Else dma_busy=1: DMA signals.
  - Else: CPU signals.
- Trigger: in IDLE with dbg_ready=1, cpu_r_nw=0 and cpu_a==DMA_TRIG_ADDR:
  - Latch cpu_dout into the page register and go to RD.
  - That cycle cpumc_r_nw is forced to 1, so the trigger write does not reach cpumc.
- FSM states: IDLE, RD, CAP, WR. The 8-bit index idx is reset to 0 on trigger.
  - RD: cpumc_a={page,idx}, r_nw=1. Next state is CAP.
  - CAP: same address held, r_nw=1. At the cycle end, capture cpumc_dout into the data register. Next state is WR.
  - WR: cpumc_a=OAMDATA_ADDR, r_nw=0, cpumc_din=data register. If idx==8'hFF, go to IDLE; else idx+1 and go to RD.
- Debugger preemption: while dbg_ready=0, the FSM, idx, page and data register all freeze. Resume from the same state once dbg_ready returns to 1.
- A trigger is ignored while dma_busy=1, because the CPU is stalled then.
- idx wraps only at completion. Addresses never leave page {page,8'h00}–{page,8'hFF}.

## Timing
- Reset values: state=IDLE, idx=0, page=0, data register=0, dma_busy=0. cpu_ready then follows dbg_ready. cpumc outputs follow the CPU or debugger combinationally.
- Trigger at cycle T:
  - dma_busy=1 and cpu_ready=0 from T+1.
  - First RD at T+1.
  - Final WR at T+768.
  - dma_busy=0 and cpu_ready=1 at T+769.
- Total stall without preemption is 768 cycles. Each debugger-owned cycle during DMA adds exactly 1 cycle.
- Reset mid-DMA: next cycle is IDLE, with no further cpumc writes from the DMA.
- A debugger break in the same cycle as a trigger: the debugger wins, and no DMA starts because the trigger condition requires dbg_ready=1.

## Structure
- Shared package/include holds DMA_TRIG_ADDR, OAMDATA_ADDR and the state encoding (2-bit localparams).
- A single module with no sub-modules. The top level instantiates cpumc_arb in place of the existing assign-mux, and feeds cpu_ready to both the CPU and the mux.

## Test plan
- Reset, CPU read at 16'h0123 → cpumc_a=16'h0123, cpumc_r_nw=1, cpu_ready=1, dma_busy=0.
- Preload page 16'h0300–16'h03FF with bytes i^8'h5A. CPU writes 8'h03 to 16'h4014 → 256 writes to 16'h2004 in order 8'h5A,8'h5B,…; trigger write not forwarded; cpu_ready low for exactly 768 cycles.
- DMA page 8'hFF → source addresses 16'hFF00–16'hFFFF, no wrap into 16'h0000; final byte written at T+768.
- dbg_ready=0 for 10 cycles starting at idx=8'h40 (CAP) → debugger address on cpumc during those cycles; DMA resumes at CAP idx=8'h40; completion delayed by 10 cycles; data sequence unbroken.
- rst asserted at idx=8'h80 → dma_busy=0 next cycle, no further writes to 16'h2004, cpu_ready=dbg_ready.
- CPU write to 16'h4013 and 16'h4015 → forwarded as normal writes, no DMA.
